// File: rtl/pio_spi_cmd_engine.sv
// pio_spi_cmd_engine: toggle-strobed PIO command word to SPI mode-0 master.
// Ports: clk, reset_n (async low), cmd_word[29:0], clr_ovf -> sclk, mosi,
// cs_n, busy, pending, overflow, ack_toggle. Optional SPI_RX_EN adds
// miso input and rx_data[23:0] output.
module pio_spi_cmd_engine #(
    parameter int CLK_DIV = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [29:0] cmd_word,
    input  logic        clr_ovf,
`ifdef SPI_RX_EN
    input  logic        miso,
    output logic [23:0] rx_data,
`endif
    output logic        sclk,
    output logic        mosi,
    output logic        cs_n,
    output logic        busy,
    output logic        pending,
    output logic        overflow,
    output logic        ack_toggle
);

    typedef enum logic [1:0] {
        IDLE,
        LOW,
        HIGH,
        FIN
    } state_t;

    localparam logic [7:0] DIV_M1 = 8'(CLK_DIV - 1);

    state_t      state;
    logic [7:0]  cnt;
    logic [4:0]  bits;
    logic [23:0] sreg;
    logic [28:0] slot;
    logic        tog_seen;
    logic        hold_r;

    logic        tog;
    logic        start;
    logic        store;
    logic        drop;
    logic        div_done;
    logic [28:0] sw;
    logic [23:0] load;
    logic [4:0]  load_bits;
    logic        unused_bits;

    assign tog      = cmd_word[29] ^ tog_seen;
    // The slot always has priority over a fresh command when idle.
    assign start    = (state == IDLE) && (pending || tog);
    assign store    = tog && !pending && (state != IDLE);
    assign drop     = tog && pending;
    assign div_done = (cnt == DIV_M1);
    assign sw       = pending ? slot : cmd_word[28:0];

    // Left-align the active payload so the MSB is always sreg[23].
    always_comb begin
        load      = sw[23:0];
        load_bits = 5'd23;
        unique case (sw[25:24])
            2'b00: begin
                load      = {sw[7:0], 16'h0000};
                load_bits = 5'd7;
            end
            2'b01: begin
                load      = {sw[15:0], 8'h00};
                load_bits = 5'd15;
            end
            default: begin
                load      = sw[23:0];
                load_bits = 5'd23;
            end
        endcase
    end

    assign unused_bits = &{1'b0, sw[27:26], sreg[23]};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            cnt        <= '0;
            bits       <= '0;
            sreg       <= '0;
            slot       <= '0;
            tog_seen   <= 1'b0;
            hold_r     <= 1'b0;
            sclk       <= 1'b0;
            mosi       <= 1'b0;
            cs_n       <= 1'b1;
            busy       <= 1'b0;
            pending    <= 1'b0;
            overflow   <= 1'b0;
            ack_toggle <= 1'b0;
`ifdef SPI_RX_EN
            rx_data    <= '0;
`endif
        end else begin
            if (tog) tog_seen <= cmd_word[29];

            if (drop) overflow <= 1'b1;
            else if (clr_ovf) overflow <= 1'b0;

            if (store) begin
                slot    <= cmd_word[28:0];
                pending <= 1'b1;
            end else if (start) begin
                pending <= 1'b0;
            end

            unique case (state)
                IDLE: begin
                    if (start) begin
                        state  <= LOW;
                        cnt    <= '0;
                        sreg   <= load;
                        mosi   <= load[23];
                        bits   <= load_bits;
                        hold_r <= sw[28];
                        cs_n   <= 1'b0;
                        sclk   <= 1'b0;
                        busy   <= 1'b1;
`ifdef SPI_RX_EN
                        rx_data <= '0;
`endif
                    end
                end
                LOW: begin
                    if (div_done) begin
                        cnt   <= '0;
                        state <= HIGH;
                        sclk  <= 1'b1;
`ifdef SPI_RX_EN
                        rx_data <= {rx_data[22:0], miso};
`endif
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                HIGH: begin
                    if (div_done) begin
                        cnt  <= '0;
                        sclk <= 1'b0;
                        if (bits != 5'd0) begin
                            bits  <= bits - 5'd1;
                            sreg  <= {sreg[22:0], 1'b0};
                            mosi  <= sreg[22];
                            state <= LOW;
                        end else begin
                            state <= FIN;
                        end
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                FIN: begin
                    if (div_done) begin
                        cnt        <= '0;
                        cs_n       <= !hold_r;
                        ack_toggle <= !ack_toggle;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
